sec_countdown: RTL and testbench

//  Consumes the 1 Hz square wave produced by the team's clock divider. Synchronises it into clk,

---
 rtl/sec_countdown.sv | 76 +++++++
 tb/tb_sec_countdown.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sec_countdown.sv
// sec_countdown: 1 Hz edge synchroniser, loadable seconds countdown with done pulse and stall watchdog.
// Optional SEC_COUNTDOWN_BCD_EN adds a registered BCD copy of count on port bcd.
module sec_countdown #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 60000000,
   parameter int TO_W    = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sq_in,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             stall
`ifdef SEC_COUNTDOWN_BCD_EN
   ,
   output logic [11:0]      bcd
`endif
);
   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
   logic s1, s2, s3, rise, state;
   logic [TO_W-1:0] wd;
   assign rise = s2 & ~s3;
   assign busy = state == RUN;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {s3, s2, s1} <= 3'b000;
         tick  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
         state <= IDLE;
      end else begin
         {s3, s2, s1} <= {s2, s1, sq_in};
         tick <= rise;
         done <= 1'b0;
         // a load wins over a coincident tick, which is simply dropped
         if (load) begin
            count <= load_val;
            state <= load_val != '0 ? RUN : IDLE;
            done  <= load_val == '0;
         end else if (state == RUN && tick && enable) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd    <= '0;
         stall <= 1'b0;
      end else if (tick) begin
         wd    <= '0;
         stall <= 1'b0;
      end else begin
         wd    <= wd == TO_MAX ? wd : wd + TO_W'(1);
         stall <= stall | (wd == TO_MAX);
      end
   end
`ifdef SEC_COUNTDOWN_BCD_EN
   logic [7:0] cv;
   assign cv = 8'(count);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bcd <= 12'h000;
      else bcd <= {4'(cv / 8'd100), 4'((cv / 8'd10) % 8'd10), 4'(cv % 8'd10)};
   end
`endif
endmodule

// File: tb/tb_sec_countdown.sv
// tb_sec_countdown: randomized and directed checks of sec_countdown against a cycle-level behavioural model.
module tb_sec_countdown;
   localparam int TO = 1000;
   logic clk = 1'b0, reset = 1'b1, sq_in = 1'b0, load = 1'b0, enable = 1'b1;
   logic [7:0] load_val = '0, count;
   logic busy, tick, done, stall;
`ifdef SEC_COUNTDOWN_BCD_EN
   logic [11:0] bcd;
`endif
   int tests = 0, fails = 0, nt = 0, nd = 0;
   int m_count, m_wd, m_bcd;
   bit m_busy, m_done, m_tick, m_stall;
   bit samp[$];

   sec_countdown #(.CNT_W(8), .TIMEOUT(TO), .TO_W(26)) dut (
      .clk(clk), .reset(reset), .sq_in(sq_in), .load(load), .load_val(load_val),
      .enable(enable), .count(count), .busy(busy), .tick(tick), .done(done), .stall(stall)
`ifdef SEC_COUNTDOWN_BCD_EN
      , .bcd(bcd)
`endif
   );

   always #5 clk = ~clk;

   function automatic int to_bcd(input int v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   function automatic void model_reset();
      m_count = 0; m_wd = 0; m_bcd = 0;
      m_busy = 0; m_done = 0; m_tick = 0; m_stall = 0;
      samp = '{1'b0, 1'b0, 1'b0};
   endfunction

   // one clock edge of the specified behaviour, inputs as they stand at the edge
   function automatic void model_update();
      bit t;
      if (reset) begin
         model_reset();
         return;
      end
      t = m_tick;
      samp.push_back(sq_in);
      m_tick = samp[samp.size()-3] & ~samp[samp.size()-4];
      while (samp.size() > 4) void'(samp.pop_front());
      m_bcd = to_bcd(m_count);
      m_done = 0;
      if (load) begin
         m_count = int'(load_val);
         m_busy = load_val != 0;
         m_done = load_val == 0;
      end else if (m_busy && t && enable) begin
         m_count = m_count - 1;
         if (m_count == 0) begin
            m_busy = 0;
            m_done = 1;
         end
      end
      if (t) begin
         m_wd = 0;
         m_stall = 0;
      end else begin
         if (m_wd == TO) m_stall = 1;
         if (m_wd < TO) m_wd++;
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input int exp);
      tests++;
      if (got !== 32'(exp)) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_count", 32'(count), m_count);
      check("m_busy", 32'(busy), int'(m_busy));
      check("m_tick", 32'(tick), int'(m_tick));
      check("m_done", 32'(done), int'(m_done));
      check("m_stall", 32'(stall), int'(m_stall));
`ifdef SEC_COUNTDOWN_BCD_EN
      check("m_bcd", 32'(bcd), m_bcd);
`endif
   end

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      nt += int'(tick);
      nd += int'(done);
   endtask

   task automatic pulse();
      sq_in = 1'b1;
      repeat (4) step();
      sq_in = 1'b0;
      repeat (4) step();
   endtask

   task automatic strobe(input int v);
      load_val = 8'(v);
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int hold;
      bit found;
      model_reset();
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();
      // reset mid-run
      strobe(5);
      pulse();
      check("pre_reset_count", 32'(count), 4);
      step();
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done_tick_stall", 32'({done, tick, stall}), 0);
      repeat (2) step();
      reset = 1'b0;
      sq_in = 1'b0;
      nt = 0;
      repeat (8) step();
      check("idle_no_tick", 32'(nt), 0);
      check("idle_no_stall", 32'(stall), 0);
      // basic countdown 3,2,1,0
      strobe(3);
      check("load3_count", 32'(count), 3);
      check("load3_busy", 32'(busy), 1);
      nd = 0;
      pulse();
      check("cd_2", 32'(count), 2);
      pulse();
      check("cd_1", 32'(count), 1);
      pulse();
      check("cd_0", 32'(count), 0);
      check("cd_busy0", 32'(busy), 0);
      check("cd_done_once", 32'(nd), 1);
      pulse();
      check("cd_no_wrap", 32'(count), 0);
      // zero load in IDLE
      strobe(0);
      check("z_done", 32'(done), 1);
      check("z_busy", 32'(busy), 0);
      check("z_count", 32'(count), 0);
      step();
      check("z_done_one_cycle", 32'(done), 0);
      // pause
      strobe(5);
      enable = 1'b0;
      nt = 0;
      pulse();
      pulse();
      check("pause_ticks", 32'(nt), 2);
      check("pause_count", 32'(count), 5);
      enable = 1'b1;
      pulse();
      check("resume_count", 32'(count), 4);
      pulse();
      pulse();
      check("pre_coinc_count", 32'(count), 2);
      // load coincident with a tick
      sq_in = 1'b1;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         step();
         found = tick;
      end
      check("coinc_tick_seen", 32'(found), 1);
      nd = 0;
      strobe(9);
      check("coinc_count", 32'(count), 9);
      check("coinc_busy", 32'(busy), 1);
      sq_in = 1'b0;
      repeat (4) step();
      check("coinc_no_done", 32'(nd), 0);
      // stall watchdog
      repeat (TO + 10) step();
      check("stall_set", 32'(stall), 1);
      pulse();
      check("stall_clear", 32'(stall), 0);
`ifdef SEC_COUNTDOWN_BCD_EN
      strobe(147);
      step();
      check("bcd_147", 32'(bcd), 32'h147);
`endif
      // randomized traffic against the model
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            sq_in = ~sq_in;
            hold = ($urandom_range(0, 300) == 0) ? TO + 50 : int'($urandom_range(1, 12));
         end
         hold--;
         load = $urandom_range(0, 15) == 0;
         load_val = 8'($urandom_range(0, 12));
         enable = $urandom_range(0, 7) != 0;
         step();
      end
      load = 1'b0;
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
